// File: rtl/dbus_sram_responder.sv
// Fixed-latency data-bus responder backed by a 64-bit word scratchpad.
// Optional alignment check: define DBUS_MISALIGN_CHECK_EN.
module dbus_sram_responder #(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [63:0] resp_data,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   // Handshake: req_valid is held with stable fields until resp_data_ok; the
   // response is a single-cycle pulse of resp_addr_ok/resp_data_ok together.

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
   localparam logic [3:0]  LAT4  = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        w_capture;
   logic        w_enter_resp;

   logic [63:0] r_addr;
   logic [2:0]  r_size;
   logic [7:0]  r_strobe;
   logic [63:0] r_data;

   logic        r_data_ok;
   logic [63:0] r_resp_data;
   logic        r_err;

   logic [63:0] r_mem [DEPTH];

   logic [63:0] w_rd_addr;
   logic [63:0] w_rd_data;
   logic        w_rd_err;
   logic        w_wr_block;
   logic        w_wr_en;

   function automatic logic in_range(input logic [63:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
      return IDX_W'((a - BASE_ADDR) >> 3);
   endfunction

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_capture    = 1'b1;
               w_cnt_next   = LAT4;
               w_state_next = (LATENCY > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_enter_resp = (w_state_next == ST_RESP);

   // With zero latency the read happens on the accepting edge, before capture.
   assign w_rd_addr = (r_state == ST_IDLE) ? req_addr : r_addr;

`ifdef DBUS_MISALIGN_CHECK_EN
   function automatic logic misaligned(input logic [63:0] a, input logic [2:0] sz);
      logic [7:0] mask;
      mask = (8'd1 << sz) - 8'd1;
      return |(a[7:0] & mask);
   endfunction

   logic [2:0] w_rd_size;
   assign w_rd_size  = (r_state == ST_IDLE) ? req_size : r_size;
   assign w_rd_err   = misaligned(w_rd_addr, w_rd_size);
   assign w_wr_block = misaligned(r_addr, r_size);
`else
   logic w_unused_size;
   assign w_unused_size = ^r_size;
   assign w_rd_err      = 1'b0;
   assign w_wr_block    = 1'b0;
`endif

   assign w_rd_data = (w_rd_err || !in_range(w_rd_addr)) ? 64'd0
                                                          : r_mem[word_idx(w_rd_addr)];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 4'd0;
         r_addr      <= 64'd0;
         r_size      <= 3'd0;
         r_strobe    <= 8'd0;
         r_data      <= 64'd0;
         r_data_ok   <= 1'b0;
         r_resp_data <= 64'd0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_capture) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_strobe <= req_strobe;
            r_data   <= req_data;
         end
         r_data_ok   <= w_enter_resp;
         r_resp_data <= w_enter_resp ? w_rd_data : 64'd0;
         r_err       <= w_enter_resp & w_rd_err;
      end
   end

   // Commit on the edge leaving RESP so the response carries the pre-write word.
   assign w_wr_en = (r_state == ST_RESP) && !reset && (r_strobe != 8'd0)
                    && in_range(r_addr) && !w_wr_block;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (r_strobe[i]) begin
               r_mem[word_idx(r_addr)][8*i +: 8] <= r_data[8*i +: 8];
            end
         end
      end
   end

   assign resp_addr_ok = r_data_ok;
   assign resp_data_ok = r_data_ok;
   assign resp_data    = r_resp_data;
   assign resp_err     = r_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: two instances (latency 2 and 0), byte-level
// reference memory, expected-response queues checked by a negedge monitor.
module tb_dbus_sram_responder;

   localparam int          DEPTH = 1024;
   localparam int          LAT_A = 2;
   localparam int          LAT_B = 0;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

   typedef struct packed {
      logic [31:0] cyc;
      logic        chk;
      logic        err;
      logic [63:0] data;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req_valid  [2];
   logic [63:0] req_addr   [2];
   logic [2:0]  req_size   [2];
   logic [7:0]  req_strobe [2];
   logic [63:0] req_data   [2];
   logic        addr_ok    [2];
   logic        data_ok    [2];
   logic [63:0] rdata      [2];
   logic        rerr       [2];
   logic [1:0]  dbg_state  [2];

   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   logic [7:0]  ref_mem [2][128];
   bit          known   [2][128];
   int          cyc;
   int          n_checks;
   int          n_errs;

   dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A), .BASE_ADDR(BASE)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
      .req_strobe(req_strobe[0]), .req_data(req_data[0]),
      .resp_addr_ok(addr_ok[0]), .resp_data_ok(data_ok[0]), .resp_data(rdata[0]),
      .resp_err(rerr[0]), .dbg_state(dbg_state[0])
   );

   dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B), .BASE_ADDR(BASE)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
      .req_strobe(req_strobe[1]), .req_data(req_data[1]),
      .resp_addr_ok(addr_ok[1]), .resp_data_ok(data_ok[1]), .resp_data(rdata[1]),
      .resp_err(rerr[1]), .dbg_state(dbg_state[1])
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int d, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
      end
   endtask

   // reference model: byte-addressed window of the first 16 words
   function automatic void model(input int d, input logic [63:0] a, input logic [2:0] sz,
                                 input logic [7:0] st, input logic [63:0] wd,
                                 output logic [63:0] rd, output logic er, output logic ck);
      logic inr;
      logic mis;
      int   wb;
      inr = (a >= BASE) && (a < BASE + SPAN);
      mis = 1'b0;
`ifdef DBUS_MISALIGN_CHECK_EN
      mis = (a % (64'd1 << sz)) != 64'd0;
`else
      if (sz > 3'd7) mis = 1'b0;
`endif
      er = mis;
      rd = 64'd0;
      ck = 1'b1;
      if (inr && !mis) begin
         wb = int'((a - BASE) / 64'd8) * 8;
         for (int i = 0; i < 8; i++) begin
            rd[8*i +: 8] = ref_mem[d][wb+i];
            if (!known[d][wb+i]) ck = 1'b0;
         end
         for (int i = 0; i < 8; i++) begin
            if (st[i]) begin
               ref_mem[d][wb+i] = wd[8*i +: 8];
               known[d][wb+i]   = 1'b1;
            end
         end
      end
   endfunction

   // driver: call at a negedge; returns at a negedge with req_valid dropped
   task automatic do_req(input int d, input logic [63:0] a, input logic [2:0] sz,
                         input logic [7:0] st, input logic [63:0] wd);
      exp_t e;
      int   lat;
      int   n;
      lat   = (d == 0) ? LAT_A : LAT_B;
      e.cyc = 32'(cyc + 1 + lat);
      model(d, a, sz, st, wd, e.data, e.err, e.chk);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      req_valid[d]  = 1'b1;
      req_addr[d]   = a;
      req_size[d]   = sz;
      req_strobe[d] = st;
      req_data[d]   = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_ok[d] && n < 40);
      if (!data_ok[d]) begin
         n_checks++;
         n_errs++;
         $display("FAIL timeout dut%0d addr %h: data_ok=0 after %0d cycles, required 1", d, a, n);
         if (d == 0) void'(exp_q0.pop_back());
         else        void'(exp_q1.pop_back());
      end
      @(negedge clk);
      req_valid[d] = 1'b0;
   endtask

   task automatic rand_req(input int d, input int nwords);
      logic [63:0] a;
      logic [2:0]  sz;
      logic [7:0]  st;
      logic [63:0] wd;
      sz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
         case ($urandom_range(0, 3))
            0:       a = BASE - 64'd8;
            1:       a = BASE + SPAN;
            2:       a = BASE + SPAN + 64'h100;
            default: a = 64'd0;
         endcase
      end else begin
         a = BASE + 64'($urandom_range(0, nwords * 8 - 1));
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      end
      st = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      wd = {$urandom, $urandom};
      do_req(d, a, sz, st, wd);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            if (data_ok[d]) begin
               if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                  n_checks++;
                  n_errs++;
                  $display("FAIL unexpected_resp dut%0d: data_ok=1 at cycle %0d, required 0", d, cyc);
               end else begin
                  if (d == 0) e = exp_q0.pop_front();
                  else        e = exp_q1.pop_front();
                  check("resp_cycle", d, 64'(cyc), 64'(e.cyc));
                  check("resp_addr_ok", d, 64'(addr_ok[d]), 64'd1);
                  check("resp_err", d, 64'(rerr[d]), 64'(e.err));
                  if (e.chk) check("resp_data", d, rdata[d], e.data);
               end
            end else begin
               check("idle_outputs", d, {rdata[d][61:0], addr_ok[d], rerr[d]}, 64'd0);
               check("idle_data_hi", d, 64'(rdata[d][63:62]), 64'd0);
            end
         end
      end
   end

   // stimulus
   initial begin
      n_checks = 0;
      n_errs   = 0;
      reset    = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_addr[d]   = 64'd0;
         req_size[d]   = 3'd0;
         req_strobe[d] = 8'd0;
         req_data[d]   = 64'd0;
         for (int i = 0; i < 128; i++) begin
            ref_mem[d][i] = 8'd0;
            known[d][i]   = 1'b0;
         end
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_data_ok", d, 64'(data_ok[d]), 64'd0);
         check("reset_addr_ok", d, 64'(addr_ok[d]), 64'd0);
         check("reset_data", d, rdata[d], 64'd0);
         check("reset_err", d, 64'(rerr[d]), 64'd0);
      end
      reset = 1'b0;
      @(negedge clk);

      // fill the model window so later reads are fully predictable
      for (int w = 0; w < 16; w++) do_req(0, BASE + 64'(w * 8), 3'd3, 8'hFF, {$urandom, $urandom});
      for (int w = 0; w < 16; w++) do_req(1, BASE + 64'(w * 8), 3'd3, 8'hFF, {$urandom, $urandom});

      // full write, read back, partial write, read back
      do_req(0, BASE + 64'h10, 3'd3, 8'hFF, 64'h1122334455667788);
      do_req(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0);
      do_req(0, BASE + 64'h10, 3'd3, 8'h0F, 64'h00000000AABBCCDD);
      do_req(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0);

      // zero-latency back-to-back reads
      do_req(1, BASE, 3'd3, 8'h00, 64'd0);
      do_req(1, BASE + 64'h8, 3'd3, 8'h00, 64'd0);

      // out-of-range writes then reads
      do_req(0, 64'h7FFF_FFF8, 3'd3, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5);
      do_req(0, BASE + SPAN, 3'd3, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
      do_req(0, 64'h7FFF_FFF8, 3'd3, 8'h00, 64'd0);
      do_req(0, BASE + SPAN, 3'd3, 8'h00, 64'd0);
      do_req(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0);

      // reset during WAIT aborts the write
      req_valid[0]  = 1'b1;
      req_addr[0]   = BASE + 64'h20;
      req_size[0]   = 3'd3;
      req_strobe[0] = 8'hFF;
      req_data[0]   = 64'h0000_0000_DEAD_BEEF;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      req_valid[0] = 1'b0;
      for (int k = 0; k < LAT_A + 3; k++) begin
         @(negedge clk);
         check("abort_no_data_ok", 0, 64'(data_ok[0]), 64'd0);
      end
      do_req(0, BASE + 64'h20, 3'd3, 8'h00, 64'd0);

      // word-size write at a half-word offset, then read the word
      do_req(0, BASE + 64'h2, 3'd2, 8'h3C, 64'h0000_CAFE_F00D_0000);
      do_req(0, BASE, 3'd3, 8'h00, 64'd0);

      // randomized traffic
      for (int k = 0; k < 80; k++) rand_req(0, 16);
      for (int k = 0; k < 40; k++) rand_req(1, 16);

      repeat (5) @(negedge clk);
      check("drain_q0", 0, 64'(exp_q0.size()), 64'd0);
      check("drain_q1", 1, 64'(exp_q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
